// File: rtl/polyphase_pkg.sv
// Shared configuration and types for the polyphase tap sequencer.
// SAMPLE_WIDTH, N and M are set here. The derived delay-line depth and
// all index widths follow from them, so every file sees the same geometry.
package polyphase_pkg;

  localparam int SAMPLE_WIDTH = 16;             // sample and coefficient width
  localparam int N            = 31;             // prototype filter length
  localparam int M            = 2;              // decimation factor / phases

  localparam int L       = (N + M - 1) / M;     // delay-line depth per phase
  localparam int PHASE_W = (M > 1) ? $clog2(M) : 1;
  localparam int TAP_W   = (L > 1) ? $clog2(L) : 1;
  localparam int COEF_AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] sample;
    logic [SAMPLE_WIDTH-1:0] coef;
    logic [PHASE_W-1:0]      phase;
    logic                    first;
    logic                    last;
    logic                    frame_end;
  } tap_tuple_t;

  // Highest k with p + k*M < N. Taps beyond it index past the prototype
  // filter and are never issued.
  function automatic logic [TAP_W-1:0] last_tap(input logic [PHASE_W-1:0] p);
    return TAP_W'((N - 1 - int'(p)) / M);
  endfunction

  // Prototype coefficient index of tap k in phase p.
  function automatic logic [COEF_AW-1:0] tap_addr(input logic [PHASE_W-1:0] p,
                                                 input logic [TAP_W-1:0]   k);
    return COEF_AW'(int'(p) + int'(k) * M);
  endfunction

endpackage

// File: rtl/polyphase_tap_sequencer_delay_bank.sv
// polyphase_delay_bank: M delay lines of depth L that share one circular
// write pointer. A write to phase 0 closes a frame and advances the
// pointer. The read port is combinational and addresses taps relative to
// the newest sample, so tap 0 is the most recent write of that phase.
module polyphase_delay_bank
  import polyphase_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [PHASE_W-1:0]      wr_phase,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic [PHASE_W-1:0]      rd_phase,
  input  logic [TAP_W-1:0]        rd_tap,
  output logic [SAMPLE_WIDTH-1:0] rd_data
);

  logic [SAMPLE_WIDTH-1:0] mem [M][L];
  logic [TAP_W-1:0]        wp_q;
  logic [TAP_W-1:0]        rd_slot;

  // Slot of tap k: (wp - 1 - k) mod L. Both operands are below L, so a
  // single conditional subtract wraps the sum into range.
  function automatic logic [TAP_W-1:0] slot_of(input logic [TAP_W-1:0] wp,
                                               input logic [TAP_W-1:0] k);
    int s;
    s = int'(wp) + L - 1 - int'(k);
    if (s >= L) s = s - L;
    return TAP_W'(s);
  endfunction

  // Write pointer: advances once per frame, on the phase-0 sample.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
    end else if (wr_en && (wr_phase == '0)) begin
      wp_q <= (wp_q == TAP_W'(L - 1)) ? '0 : wp_q + 1'b1;
    end
  end

  // Sample storage: commutated samples land in their phase line at the
  // current write slot.
  // NOTE: this array is reset on purpose. The first frames after reset
  // must read zeros from taps that have never been written, so it is built
  // from flops rather than a RAM macro that cannot be cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < M; p++) begin
        for (int k = 0; k < L; k++) begin
          mem[p][k] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_phase][wp_q] <= wr_data;
    end
  end

  // Tap read port: newest-first addressing into the selected phase.
  always_comb begin
    rd_slot = slot_of(wp_q, rd_tap);
    rd_data = mem[rd_phase][rd_slot];
  end

endmodule

// File: rtl/polyphase_tap_sequencer.sv
// polyphase_tap_sequencer: commutates input samples across M phase delay
// lines. Once per decimated frame it walks every valid tap of every phase
// and emits one (sample, coefficient) tuple per cycle to the MAC stage.
// The coefficient ROM is external and synchronous, with 1-cycle latency.
//
// Optional feature: define POLY_OVERRUN_EN to add the overrun and
// overrun_count outputs, which record input attempts made while in_ready
// is low.
//
// Pipeline: stage A holds the tap being addressed. It drives coef_addr
// and reads the delay bank. Stage B holds the tap being presented.
// out_coef is taken directly from coef_data: the ROM is addressed with
// stage A's tap on the same edge that moves that tap into stage B. While
// stage B is stalled, coef_addr replays stage B's address, so the ROM
// output stays aligned with the held tuple.
module polyphase_tap_sequencer
  import polyphase_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  output logic [COEF_AW-1:0]      coef_addr,
  input  logic [SAMPLE_WIDTH-1:0] coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] out_sample,
  output logic [SAMPLE_WIDTH-1:0] out_coef,
  output logic [PHASE_W-1:0]      out_phase,
  output logic                    out_first,
  output logic                    out_last,
`ifdef POLY_OVERRUN_EN
  output logic                    overrun,
  output logic [7:0]              overrun_count,
`endif
  output logic                    out_frame_end
);

  // Control state
  state_t             state_q;
  state_t             state_d;
  logic [PHASE_W-1:0] cnt_q;
  logic               in_ready_q;

  // Stage A: tap currently addressed
  logic [PHASE_W-1:0] a_phase_q;
  logic [TAP_W-1:0]   a_tap_q;

  // Stage B: tap currently presented
  logic                    b_valid_q;
  logic [SAMPLE_WIDTH-1:0] b_sample_q;
  logic [PHASE_W-1:0]      b_phase_q;
  logic                    b_first_q;
  logic                    b_last_q;
  logic                    b_frame_end_q;
  logic [COEF_AW-1:0]      b_addr_q;

  logic                    in_fire;
  logic                    out_fire;
  logic                    advance;
  logic                    a_live;
  logic                    a_last;
  logic                    a_frame_end;
  logic [COEF_AW-1:0]      a_addr;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  tap_tuple_t              out_tuple;

  polyphase_delay_bank u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (in_fire),
    .wr_phase (cnt_q),
    .wr_data  (in_data),
    .rd_phase (a_phase_q),
    .rd_tap   (a_tap_q),
    .rd_data  (rd_data)
  );

  // Handshake and stage-A decode. Stage A is live exactly while in ISSUE.
  always_comb begin
    in_fire     = in_valid && in_ready_q;
    out_fire    = b_valid_q && out_ready;
    advance     = !b_valid_q || out_ready;
    a_live      = (state_q == ISSUE);
    a_last      = (a_tap_q == last_tap(a_phase_q));
    a_frame_end = a_last && (a_phase_q == PHASE_W'(M - 1));
    a_addr      = tap_addr(a_phase_q, a_tap_q);
  end

  // Frame sequencing: collect M samples, issue every tap, then wait for
  // the frame-end tuple to be accepted.
  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (in_fire && (cnt_q == '0))           state_d = ISSUE;
      ISSUE:   if (advance && a_frame_end)              state_d = DRAIN;
      DRAIN:   if (out_fire && b_frame_end_q)           state_d = FILL;
      default:                                          state_d = FILL;
    endcase
  end

  // State, commutator counter, and registered in_ready. in_ready follows
  // the next state, so it drops right after the phase-0 sample and rises
  // one cycle after the frame-end handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      cnt_q      <= PHASE_W'(M - 1);
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == FILL);
      if (in_fire) begin
        cnt_q <= (cnt_q == '0) ? PHASE_W'(M - 1) : cnt_q - 1'b1;
      end
    end
  end

  // Stage A walk: phase-major, tap-minor. Taps beyond the filter length
  // are skipped by jumping to the next phase after its last valid tap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_phase_q <= '0;
      a_tap_q   <= '0;
    end else if (in_fire && (cnt_q == '0)) begin
      a_phase_q <= '0;
      a_tap_q   <= '0;
    end else if (a_live && advance) begin
      if (a_last) begin
        a_phase_q <= a_phase_q + 1'b1;
        a_tap_q   <= '0;
      end else begin
        a_tap_q   <= a_tap_q + 1'b1;
      end
    end
  end

  // Stage B: load the addressed tap whenever the output slot is free or
  // being consumed. Otherwise hold, which keeps the outputs stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid_q     <= 1'b0;
      b_sample_q    <= '0;
      b_phase_q     <= '0;
      b_first_q     <= 1'b0;
      b_last_q      <= 1'b0;
      b_frame_end_q <= 1'b0;
      b_addr_q      <= '0;
    end else if (advance) begin
      b_valid_q     <= a_live;
      b_sample_q    <= rd_data;
      b_phase_q     <= a_phase_q;
      b_first_q     <= (a_tap_q == '0);
      b_last_q      <= a_last;
      b_frame_end_q <= a_frame_end;
      b_addr_q      <= a_addr;
    end
  end

  // ROM address: replay the presented tap while stalled, otherwise
  // address the next tap. Zero when there is nothing to fetch.
  always_comb begin
    coef_addr = '0;
    if (!advance) begin
      coef_addr = b_addr_q;
    end else if (a_live) begin
      coef_addr = a_addr;
    end
  end

  // Output tuple: all-zero whenever no tuple is presented, including
  // immediately under reset.
  always_comb begin
    out_tuple = '0;
    if (b_valid_q) begin
      out_tuple.sample    = b_sample_q;
      out_tuple.coef      = coef_data;
      out_tuple.phase     = b_phase_q;
      out_tuple.first     = b_first_q;
      out_tuple.last      = b_last_q;
      out_tuple.frame_end = b_frame_end_q;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = b_valid_q;
  assign out_sample    = out_tuple.sample;
  assign out_coef      = out_tuple.coef;
  assign out_phase     = out_tuple.phase;
  assign out_first     = out_tuple.first;
  assign out_last      = out_tuple.last;
  assign out_frame_end = out_tuple.frame_end;

`ifdef POLY_OVERRUN_EN
  // Overrun monitor: sticky flag plus saturating count of cycles where the
  // upstream presented data while the block was not ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else if (in_valid && !in_ready_q) begin
      overrun <= 1'b1;
      if (overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/polyphase_tap_sequencer.md
Name: polyphase_tap_sequencer

Overview:
Upstream feeder for the polyphase MAC stage. Commutates the incoming sample stream across M phase delay lines. Once per decimated output frame, it walks every valid tap of every phase and issues one (sample, coefficient) tuple per cycle with phase and boundary flags. Coefficients come from an external synchronous ROM; the downstream MAC consumes the tuples under a valid/ready handshake.

Parameters:
SAMPLE_WIDTH, 16, sample and coefficient width (bits)
N, 31, prototype filter length (total taps)
M, 2, decimation factor = number of phases
(derived, package) L = ceil(N/M) = 16, delay-line depth per phase

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts an input sample
in_data  in  SAMPLE_WIDTH  input sample
coef_addr  out  clog2(N)  prototype coefficient index p + k*M
coef_data  in  SAMPLE_WIDTH  ROM data, 1-cycle read latency from coef_addr
out_valid  out  1  tuple valid
out_ready  in  1  downstream accepts tuple
out_sample  out  SAMPLE_WIDTH  delayed sample x_p[k]
out_coef  out  SAMPLE_WIDTH  coefficient h[p + k*M]
out_phase  out  clog2(M)  phase index p
out_first  out  1  tuple is tap 0 of its phase
out_last  out  1  tuple is last valid tap of its phase
out_frame_end  out  1  tuple is final tuple of the frame

Behaviour:
- Reset (async, any state): all outputs 0, in_ready 0 during reset, M x L buffer cleared to 0, write pointer 0, phase counter M-1, state FILL.
- FSM: FILL -> ISSUE -> DRAIN -> FILL.
- FILL: in_ready=1. Each accepted sample is written to phase[cnt] at slot wp. cnt counts M-1 down to 0, so the first sample of a frame lands in phase M-1 and the last in phase 0.
- On accepting the phase-0 sample: wp advances (mod L, wraps L-1 -> 0), cnt reloads M-1, go to ISSUE.
- ISSUE: in_ready=0. Walk p = 0..M-1; for each p walk k = 0..L-1.
- Tap index p + k*M >= N is skipped, with no tuple and no cycle spent. For N=31, M=2: phase 0 issues 16 taps, phase 1 issues 15 taps, 31 tuples total.
- Sample read for tap k is slot (wp_new - 1 - k) mod L, i.e. newest first.
- Two-stage pipeline: stage A drives coef_addr and reads the buffer sample; stage B registers out_* with coef_data.
- Stage A advances only when !out_valid || out_ready. When stalled, coef_addr is held so coef_data remains valid.
- Throughput is 1 tuple/cycle with out_ready high. The first tuple has out_valid=1 on the 2nd cycle after the accepting phase-0 handshake.
- After the last address is issued, go to DRAIN. DRAIN goes to FILL on the cycle the out_frame_end tuple handshakes. in_ready rises the following cycle; no sample is accepted while a frame is outstanding.
- Outputs hold stable while out_valid && !out_ready.
- out_valid drops after the final handshake unless a new tuple is present; no bubbles are inserted within a frame.
- Flag rules:
  - out_first: k = 0.
  - out_last: highest valid k for that p.
  - out_frame_end: out_last && p = M-1.
- in_valid while in_ready=0 is ignored; the upstream must hold.
- Width: no arithmetic on samples; pointers wrap modulo L, counters modulo M.

Optional Feature:
POLY_OVERRUN_EN:
- Defined: adds outputs overrun (1 bit) and overrun_count (8 bits).
  - overrun is a sticky flag set on any cycle with in_valid && !in_ready.
  - overrun_count increments on those cycles and saturates at 255.
  - Both are cleared only by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package polyphase_pkg holds:
  - localparams L, PHASE_W = clog2(M), TAP_W = clog2(L), COEF_AW = clog2(N);
  - the state enum type {FILL, ISSUE, DRAIN};
  - a packed struct tap_tuple_t {sample, coef, phase, first, last, frame_end}.
- One natural sub-module: polyphase_delay_bank. It owns the M x L register array, write pointer, wrap arithmetic and combinational tap read port.

Test Plan:
- Reset then feed 1,2 (M=2) with out_ready=1 -> 31 tuples on consecutive cycles. Phase 0 tap 0 sample = 2, phase 1 tap 0 sample = 1, all other samples 0. out_frame_end only on tuple 31.
- ROM model h[i]=i+100 -> out_coef sequence 100,102,...,130 then 101,...,129. coef_addr never reaches 31.
- Feed 40 frames of ramp samples -> tap k of phase p equals the sample from k frames earlier; wp wrap at L=16 is verified against a reference model.
- out_ready toggling 1,0,0,1 during ISSUE -> outputs stable while stalled, no tuple lost or duplicated, still 31 tuples.
- Assert reset mid-ISSUE (tuple 10) -> outputs 0 in the same cycle, buffer cleared. The next frame after samples 5,6 shows only 6 and 5 nonzero.
- With POLY_OVERRUN_EN, hold in_valid=1 throughout ISSUE of 31 cycles plus latency -> overrun=1, count equals stall cycles. 300 stalled cycles -> count=255.
